// File: rtl/dense_activate_pipe.sv
// Elastic 2-entry skid register between the dense and activation stages.
// Carries the full stage bundle bit-exact with a registered in_ready.
module dense_activate_pipe #(
  parameter int size                   = 3,
  parameter int data_size              = 16,
  parameter int cost_type_size         = 8,
  parameter int dense_type_size        = 4,
  parameter int act_type_size          = 4,
  parameter int backprop_controll_size = 100
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [act_type_size-1:0]          act_type,
  input  logic [dense_type_size-1:0]        dense_type,
  input  logic [cost_type_size-1:0]         cost_type,
  input  logic [data_size*size-1:0]         w,
  input  logic [data_size*size-1:0]         y,
  input  logic [data_size*size-1:0]         x,
  input  logic [data_size*size-1:0]         predict_value,
  input  logic [backprop_controll_size-1:0] backprop_controll,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [act_type_size-1:0]          act_type_out,
  output logic [dense_type_size-1:0]        dense_type_out,
  output logic [cost_type_size-1:0]         cost_type_out,
  output logic [data_size*size-1:0]         w_out,
  output logic [data_size*size-1:0]         y_out,
  output logic [data_size*size-1:0]         x_out,
  output logic [data_size*size-1:0]         predict_value_out,
  output logic [backprop_controll_size-1:0] backprop_controll_out,
  output logic [1:0]                        occupancy
);

  localparam int VW = data_size * size;
  localparam int BW = act_type_size + dense_type_size + cost_type_size
                    + 4 * VW + backprop_controll_size;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_main;
  logic [BW-1:0]   r_skid;
  logic [BW-1:0]   w_in_bundle;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_ld_main_in;
  logic            w_ld_main_skid;
  logic            w_ld_skid;

  assign w_in_bundle = {act_type, dense_type, cost_type,
                        w, y, x, predict_value, backprop_controll};

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt  = ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt    = ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      if (w_ld_main_in)   r_main <= w_in_bundle;
      if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)      r_skid <= w_in_bundle;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign occupancy = r_state;

  assign {act_type_out, dense_type_out, cost_type_out,
          w_out, y_out, x_out, predict_value_out,
          backprop_controll_out} = r_main;

endmodule

// File: doc/dense_activate_pipe.md
Name: dense_activate_pipe

Overview:
- Elastic pipeline register between the dense stage and the activation stage; the successor to the fixed one-cycle delay bank.
- Carries the full stage bundle: act/dense/cost type, w, y, x, predict_value and backprop control.
- Adds a valid/ready handshake, a 2-entry skid buffer so throughput is one beat per cycle with registered in_ready, a synchronous flush, and an occupancy output.

Parameters:
- size, 3, vector element count for w/y/x/predict_value
- data_size, 16, bits per element
- cost_type_size, 8, cost type width
- dense_type_size, 4, dense type width
- act_type_size, 4, activation type width
- backprop_controll_size, 100, backprop control width (32*3+4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous drop of all buffered beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  block can accept a beat (registered)
- act_type  in  act_type_size  activation type
- dense_type  in  dense_type_size  dense type
- cost_type  in  cost_type_size  cost type
- w  in  data_size*size  weights
- y  in  data_size*size  target
- x  in  data_size*size  input
- predict_value  in  data_size*size  prediction
- backprop_controll  in  backprop_controll_size  backprop control
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- act_type_out  out  act_type_size  output fields, same widths as the inputs
- dense_type_out  out  dense_type_size
- cost_type_out  out  cost_type_size
- w_out  out  data_size*size
- y_out  out  data_size*size
- x_out  out  data_size*size
- predict_value_out  out  data_size*size
- backprop_controll_out  out  backprop_controll_size
- occupancy  out  2  beats held (0..2)

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Internal storage: main register (drives the *_out fields) and skid register, each holding the full bundle.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY: occ 0, out_valid 0, in_ready 1.
  - ONE: occ 1, out_valid 1, in_ready 1.
  - FULL: occ 2, out_valid 1, in_ready 0.
- EMPTY transitions:
  - in_fire -> ONE; bundle loads into main.
  - No in_fire -> stay EMPTY.
- ONE transitions:
  - in_fire & out_fire -> ONE; main loads the new bundle.
  - in_fire only -> FULL; bundle loads into skid.
  - out_fire only -> EMPTY.
  - Neither -> hold.
- FULL transitions:
  - out_fire -> ONE; main <= skid.
  - No out_fire -> hold. in_fire cannot occur because in_ready is 0.
- Latency: a beat accepted in cycle N appears on the outputs with out_valid in cycle N+1 when the block was EMPTY.
- Ordering: strict FIFO. No beat is dropped or duplicated except on flush or reset.
- Output stability: while out_valid=1 and out_ready=0, every *_out field is held stable.
- in_ready is a register output. It does not depend combinationally on out_ready.
- Flush:
  - Next state EMPTY, occ 0, out_valid 0, in_ready 1.
  - A beat presented in the flush cycle is discarded, even if in_valid=1.
  - *_out fields keep their last value; they are don't-care while out_valid=0.
- Reset:
  - Has priority over flush and all handshakes, including mid-operation.
  - Values after reset: out_valid 0, in_ready 1, occupancy 0, all *_out fields 0, skid register 0.
- Data path: pure pass-through, bit-exact, with no arithmetic or width change. The field packing is unchanged from the existing delay bank.
- occupancy is registered and equals the state encoding.
- out_valid=0 with in_valid=1 is a legal accept. The block never stalls upstream while not FULL.

Test Plan:
- Reset then stream: hold reset 2 cycles, then present 8 beats (w=16'h0001..0008 per element) with out_ready=1 throughout -> first out_valid one cycle after the first accept; then one beat per cycle, in order; occupancy stays 1; in_ready stays 1.
- Backpressure fill: out_ready=0, push beats A (x=16'h00AA) and B (x=16'h00BB) -> occupancy 2, in_ready=0 the cycle after B; x_out stays 16'h00AA; beat C held upstream is not accepted.
- Drain from FULL: from the previous state set out_ready=1 -> A then B then C emerge on consecutive cycles; in_ready returns to 1 one cycle after A leaves.
- Simultaneous in/out in ONE: 100 cycles of random in_valid/out_ready -> scoreboard shows no loss or reorder; in_ready never low unless occupancy=2.
- Flush: in FULL, assert flush with in_valid=1 carrying D -> next cycle occupancy 0, out_valid 0; D never appears at the output.
- Reset mid-operation: in FULL with out_ready=0, assert reset together with flush -> next cycle all outputs 0, in_ready 1; a subsequent beat E passes with 1-cycle latency.
